// File: rtl/lfsr_word_serializer.sv
// lfsr_word_serializer
// Captures free-running LFSR words into a small circular FIFO and emits them
// MSB-first as a serial bit stream over a valid/ready handshake. The LFSR
// cannot be stalled, so words that arrive while the FIFO is full are dropped
// and counted in a saturating counter. All outputs are decoded from registers.

module lfsr_word_serializer #(
    parameter int WIDTH  = 28,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     out_bit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]        drop_count
);

    // Pointer width, level width and bit counter width
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);

    localparam logic [AW:0]       FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]       LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]     PTR_ONE    = AW'(1);
    localparam logic [CW-1:0]     LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
    localparam logic [DROP_W-1:0] DROP_ONE   = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX   = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;

    logic fifo_nonempty;
    logic fifo_full;
    logic bit_accept;
    logic last_accept;
    logic load;
    logic shift_en;
    logic clear_cnt;
    logic push;
    logic drop;

    // Handshake decodes derived from registered state only
    always_comb begin
        fifo_nonempty = 1'b0;
        fifo_full     = 1'b0;
        bit_accept    = 1'b0;
        last_accept   = 1'b0;
        fifo_nonempty = (fifo_level != '0);
        fifo_full     = (fifo_level == FULL_LEVEL);
        bit_accept    = (state == SHIFT) && out_ready;
        last_accept   = bit_accept && (bit_cnt == LAST_BIT);
    end

    // Next-state and shifter control; a finished word is followed directly
    // by the next one when the FIFO holds data, so there is no bubble
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        clear_cnt  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_nonempty) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_accept) begin
                    if (fifo_nonempty) begin
                        load = 1'b1;
                    end else begin
                        shift_en   = 1'b1;
                        clear_cnt  = 1'b1;
                        state_next = IDLE;
                    end
                end else if (bit_accept) begin
                    shift_en = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write acceptance: a full FIFO still takes a word when the head leaves
    // in the same cycle, otherwise the word is lost
    always_comb begin
        push = 1'b0;
        drop = 1'b0;
        if (in_valid) begin
            if (!fifo_full || load) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO storage; contents are meaningless while the level says empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, load})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Shift register and bit position; the final shift of a word empties
    // the register so out_bit rests at 0 while idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= mem[rd_ptr];
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (clear_cnt) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
            end
        end
    end

    // Saturating count of words lost to a full FIFO
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_count <= '0;
        end else if (drop && (drop_count != DROP_MAX)) begin
            drop_count <= drop_count + DROP_ONE;
        end
    end

    // Serial outputs decoded from registers
    always_comb begin
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        out_valid = (state == SHIFT);
        out_bit   = shreg[WIDTH-1];
        out_last  = (state == SHIFT) && (bit_cnt == LAST_BIT);
    end

endmodule

// File: tb/tb_lfsr_word_serializer.sv
// tb_lfsr_word_serializer
// Directed scenarios for the serializer: reset, single word, backpressure,
// overflow, full-plus-pop, a live LFSR stream and drop saturation with an
// asynchronous reset. A second instance with a 4-bit drop counter runs on
// the same stimulus to exercise saturation.

module tb_lfsr_word_serializer;

    localparam int W = 28;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;

    logic         out_bit;
    logic         out_valid;
    logic         out_last;
    logic [2:0]   fifo_level;
    logic [15:0]  drop_count;

    logic         sat_out_bit;
    logic         sat_out_valid;
    logic         sat_out_last;
    logic [2:0]   sat_fifo_level;
    logic [3:0]   sat_drop_count;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] got[$];
    logic [W-1:0] asm_word = '0;
    int           asm_cnt = 0;

    lfsr_word_serializer #(.WIDTH(W), .DEPTH(4), .DROP_W(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    lfsr_word_serializer #(.WIDTH(W), .DEPTH(4), .DROP_W(4)) dut_sat (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_bit    (sat_out_bit),
        .out_valid  (sat_out_valid),
        .out_ready  (out_ready),
        .out_last   (sat_out_last),
        .fifo_level (sat_fifo_level),
        .drop_count (sat_drop_count)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_collector();
        got.delete();
        asm_cnt  = 0;
        asm_word = '0;
    endtask

    task automatic accept_cycle();
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            asm_word = {asm_word[W-2:0], out_bit};
            asm_cnt++;
            if (asm_cnt == W) begin
                got.push_back(asm_word);
                asm_cnt = 0;
            end
        end
        tick();
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        resetn    = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if ({out_valid, out_bit, out_last} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", {out_valid, out_bit, out_last}, 3'b000);
        end
        vectors++;
        if (fifo_level !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level);
        end
        vectors++;
        if (drop_count !== 16'd0 || sat_drop_count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_drops: got %0d/%0d expected 0/0", drop_count, sat_drop_count);
        end
        resetn = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle_after_release: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] word;
        logic         exp_last;
        word      = 28'h8000001;
        out_ready = 1'b1;
        in_data   = word;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_latency_edge1: got %b expected 0", out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_latency_edge2: got %b expected 1", out_valid);
        end
        for (int i = 0; i < W; i++) begin
            exp_last = (i == W - 1);
            vectors++;
            if ({out_valid, out_bit, out_last} !== {1'b1, word[W-1-i], exp_last}) begin
                miscompares++;
                $display("[TB] FAIL single_bit%0d: got vbl=%b expected %b", i,
                         {out_valid, out_bit, out_last}, {1'b1, word[W-1-i], exp_last});
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_back_to_idle: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] word;
        logic [W-1:0] rx;
        logic [3:0]   pat;
        logic         prev_hold;
        logic         prev_bit;
        logic         prev_last;
        int           nbits;
        word      = 28'hAAAAAAA;
        pat       = 4'b1001;
        rx        = '0;
        nbits     = 0;
        prev_hold = 1'b0;
        prev_bit  = 1'b0;
        prev_last = 1'b0;
        out_ready = 1'b0;
        in_data   = word;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 200; k++) begin
            if (prev_hold) begin
                vectors++;
                if (out_bit !== prev_bit || out_last !== prev_last) begin
                    miscompares++;
                    $display("[TB] FAIL bp_hold_cycle%0d: got bit/last %b%b expected %b%b",
                             k, out_bit, out_last, prev_bit, prev_last);
                end
            end
            out_ready = pat[3 - (k % 4)];
            if (out_valid === 1'b1 && out_ready) begin
                rx = {rx[W-2:0], out_bit};
                nbits++;
            end
            prev_hold = (out_valid === 1'b1) && !out_ready;
            prev_bit  = out_bit;
            prev_last = out_last;
            tick();
            if (nbits == W) break;
        end
        vectors++;
        if (nbits != W || rx !== word) begin
            miscompares++;
            $display("[TB] FAIL bp_word: got %h (%0d bits) expected %h (%0d bits)", rx, nbits, word, W);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_idle_after: got %b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int bubbles;
        apply_reset();
        out_ready = 1'b0;
        for (int w = 1; w <= 8; w++) begin
            in_data  = W'(w);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL ovf_level: got %0d expected 4", fifo_level);
        end
        vectors++;
        if (drop_count !== 16'd3 || sat_drop_count !== 4'd3) begin
            miscompares++;
            $display("[TB] FAIL ovf_drops: got %0d/%0d expected 3/3", drop_count, sat_drop_count);
        end
        clear_collector();
        out_ready = 1'b1;
        bubbles   = 0;
        for (int c = 0; c < 5 * W; c++) begin
            if (out_valid !== 1'b1) bubbles++;
            accept_cycle();
        end
        vectors++;
        if (bubbles != 0) begin
            miscompares++;
            $display("[TB] FAIL ovf_continuous: got %0d bubbles expected 0", bubbles);
        end
        vectors++;
        if (got.size() != 5) begin
            miscompares++;
            $display("[TB] FAIL ovf_word_count: got %0d expected 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== W'(i + 1)) begin
                miscompares++;
                $display("[TB] FAIL ovf_word%0d: got %h expected %h", i, got[i], W'(i + 1));
            end
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_idle_after: got %b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_and_pop();
        logic [W-1:0] words[6];
        words[0] = 28'hF000001;
        words[1] = 28'h0123456;
        words[2] = 28'h789ABCD;
        words[3] = 28'h0FEDCBA;
        words[4] = 28'h5555555;
        words[5] = 28'h3C3C3C3;
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data  = words[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL fp_level_full: got %0d expected 4", fifo_level);
        end
        clear_collector();
        out_ready = 1'b1;
        for (int c = 0; c < W - 1; c++) accept_cycle();
        vectors++;
        if (out_last !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fp_at_last_bit: got %b expected 1", out_last);
        end
        in_data  = words[5];
        in_valid = 1'b1;
        accept_cycle();
        in_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4 || drop_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL fp_level_drops: got %0d/%0d expected 4/0", fifo_level, drop_count);
        end
        vectors++;
        if ({out_valid, out_last} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL fp_no_bubble: got %b expected 10", {out_valid, out_last});
        end
        for (int c = 0; c < 5 * W; c++) accept_cycle();
        vectors++;
        if (got.size() != 6) begin
            miscompares++;
            $display("[TB] FAIL fp_word_count: got %0d expected 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== words[i]) begin
                miscompares++;
                $display("[TB] FAIL fp_word%0d: got %h expected %h", i, got[i], words[i]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_lfsr_stream();
        // Model of the upstream lfsr1 stage: x^28 + x^25 + 1, advancing every clock
        logic [W-1:0] lfsr;
        logic [W-1:0] exp_q[$];
        lfsr = 28'h0000001;
        apply_reset();
        clear_collector();
        out_ready = 1'b1;
        for (int c = 0; c < 256 * W; c++) begin
            in_valid = ((c % W) == 0);
            in_data  = lfsr;
            if (in_valid) exp_q.push_back(lfsr);
            accept_cycle();
            lfsr = {lfsr[W-2:0], lfsr[W-1] ^ lfsr[W-4]};
        end
        in_valid = 1'b0;
        for (int c = 0; c < 2 * W; c++) accept_cycle();
        vectors++;
        if (drop_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL lfsr_drops: got %0d expected 0", drop_count);
        end
        vectors++;
        if (got.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL lfsr_word_count: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL lfsr_word%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation_and_async_reset();
        logic [W-1:0] fresh;
        fresh = 28'h9ABCDEF;
        apply_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            in_data  = {4'hF, 24'(i)};
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (sat_drop_count !== 4'd15) begin
            miscompares++;
            $display("[TB] FAIL sat_drop_hold: got %0d expected 15", sat_drop_count);
        end
        vectors++;
        if (drop_count !== 16'd25 || fifo_level !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL sat_wide_drops_level: got %0d/%0d expected 25/4", drop_count, fifo_level);
        end
        out_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if ({out_valid, out_bit} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL sat_mid_word: got %b expected 11", {out_valid, out_bit});
        end
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_bit, out_last} !== 3'b000 || fifo_level !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_outputs: got vbl=%b level=%0d expected 000/0",
                     {out_valid, out_bit, out_last}, fifo_level);
        end
        vectors++;
        if (drop_count !== 16'd0 || sat_drop_count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_drops: got %0d/%0d expected 0/0", drop_count, sat_drop_count);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_no_partial: got %b expected 0", out_valid);
        end
        clear_collector();
        in_data  = fresh;
        in_valid = 1'b1;
        accept_cycle();
        in_valid = 1'b0;
        for (int c = 0; c < W + 12; c++) accept_cycle();
        vectors++;
        if (got.size() != 1 || got[0] !== fresh) begin
            miscompares++;
            $display("[TB] FAIL async_fresh_word: got %0d words first %h expected 1 word %h",
                     got.size(), (got.size() > 0) ? got[0] : '0, fresh);
        end
        out_ready = 1'b0;
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_overflow();
        test_full_and_pop();
        test_lfsr_stream();
        test_saturation_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
